// File: rtl/avalon.sv
// Avalon-ST timing adapter: the source has no ready signal, so its words are buffered in a
// small FIFO for a ready-aware sink. Words that arrive while the FIFO is full are dropped and counted.
module avalon #(
  parameter  int DATA_W = 40,
  parameter  int ERR_W  = 7,
  parameter  int DEPTH  = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ERR_W-1:0]  in_error,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ERR_W-1:0]  out_error,
  output logic [AW:0]       fill_level,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam int PW = DATA_W + ERR_W;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          drop;

  // A pop in the same cycle frees a slot, so a full FIFO can still take a word.
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && ((count < FULL) || pop);
  assign drop      = in_valid && !push;

  assign {out_data, out_error} = mem[rd_ptr];
  assign fill_level            = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {in_data, in_error};
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_avalon.sv
// Bench for the avalon timing adapter: a queue model checked every cycle plus directed
// scenarios with literal expectations.
module tb_avalon;

  localparam int DATA_W = 40;
  localparam int ERR_W  = 7;
  localparam int DEPTH  = 8;
  localparam int AW     = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [ERR_W-1:0]  in_error = '0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ERR_W-1:0]  out_error;
  logic [AW:0]       fill_level;
  logic              overflow;
  logic [7:0]        drop_count;

  int total = 0;
  int bad = 0;
  int delivered = 0;

  logic [DATA_W+ERR_W-1:0] model_q [$];
  int model_drops = 0;
  bit model_ovf = 1'b0;
  bit m_pop;
  bit m_push;

  avalon #(.DATA_W(DATA_W), .ERR_W(ERR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_error(in_error), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_error(out_error), .fill_level(fill_level),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d,
                               input logic [ERR_W-1:0] e, input logic r);
    in_valid  = v;
    in_data   = d;
    in_error  = e;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  // Reference: an ideal bounded queue that refuses words only when full and not being drained.
  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      model_q.delete();
      model_drops = 0;
      model_ovf = 1'b0;
    end else begin
      m_pop  = (model_q.size() != 0) && out_ready;
      m_push = in_valid && ((model_q.size() < DEPTH) || m_pop);
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back({in_data, in_error});
      else if (in_valid) begin
        model_drops++;
        model_ovf = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      checkOutput("rst_valid", out_valid, 0);
      checkOutput("rst_fill", fill_level, 0);
      checkOutput("rst_ovf", overflow, 0);
      checkOutput("rst_drops", drop_count, 0);
      checkOutput("rst_data", out_data, 0);
      checkOutput("rst_error", out_error, 0);
    end else begin
      checkOutput("cmp_valid", out_valid, model_q.size() != 0);
      checkOutput("cmp_fill", fill_level, model_q.size());
      checkOutput("cmp_ovf", overflow, model_ovf);
      checkOutput("cmp_drops", drop_count, (model_drops > 255) ? 255 : model_drops);
      if (model_q.size() != 0) begin
        checkOutput("cmp_data", out_data, model_q[0][DATA_W+ERR_W-1:ERR_W]);
        checkOutput("cmp_error", out_error, model_q[0][ERR_W-1:0]);
      end
      if (out_valid && out_ready) delivered++;
    end
  end

  initial begin
    int d0;
    int m0;

    #2;
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_fill", fill_level, 0);
    checkOutput("reset_ovf", overflow, 0);
    checkOutput("reset_drops", drop_count, 0);
    checkOutput("reset_data", out_data, 0);
    checkOutput("reset_error", out_error, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 40'(i), 7'(i), 1'b1);
      checkOutput("pt_head", out_data, i);
      checkOutput("pt_err", out_error, i);
      checkOutput("pt_fill", fill_level, 1);
    end
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("pt_empty", out_valid, 0);
    checkOutput("pt_ovf", overflow, 0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 40'('h100 + i), 7'(i), 1'b0);
    checkOutput("fill_level8", fill_level, 8);
    checkOutput("fill_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_head", out_data, 'h100 + i);
      applyStimulus(1'b0, '0, '0, 1'b1);
    end
    checkOutput("drain_valid", out_valid, 0);
    checkOutput("drain_fill", fill_level, 0);

    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 40'('h200 + i), 7'(i), 1'b0);
    applyStimulus(1'b1, 40'h2FF, 7'h7F, 1'b1);
    checkOutput("fullpop_fill", fill_level, 8);
    checkOutput("fullpop_drops", drop_count, 0);
    checkOutput("fullpop_head", out_data, 'h201);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("fullpop_empty", out_valid, 0);

    for (int i = 0; i < 11; i++) applyStimulus(1'b1, 40'('h300 + i), 7'(i), 1'b0);
    checkOutput("ovf_flag", overflow, 1);
    checkOutput("ovf_drops", drop_count, 3);
    checkOutput("ovf_fill", fill_level, 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("ovf_head", out_data, 'h300 + i);
      checkOutput("ovf_herr", out_error, i);
      applyStimulus(1'b0, '0, '0, 1'b1);
    end
    checkOutput("ovf_empty", out_valid, 0);

    d0 = delivered;
    m0 = model_drops;
    for (int i = 0; i < 1000; i++)
      applyStimulus(1'b1, 40'('h4000 + i), 7'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("rand_empty", out_valid, 0);
    checkOutput("rand_account", (delivered - d0) + (model_drops - m0), 1000);

    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 40'('h5000 + i), '0, 1'b0);
    checkOutput("sat_drops", drop_count, 255);
    checkOutput("sat_ovf", overflow, 1);
    checkOutput("sat_fill", fill_level, 8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, '0, 1'b1);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 40'('h600 + i), 7'(i + 1), 1'b0);
    checkOutput("mid_fill5", fill_level, 5);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("mid_valid", out_valid, 0);
    checkOutput("mid_fill", fill_level, 0);
    checkOutput("mid_ovf", overflow, 0);
    checkOutput("mid_drops", drop_count, 0);
    checkOutput("mid_data", out_data, 0);
    checkOutput("mid_error", out_error, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    applyStimulus(1'b1, 40'h5AA, 7'h55, 1'b1);
    checkOutput("post_valid", out_valid, 1);
    checkOutput("post_data", out_data, 'h5AA);
    checkOutput("post_error", out_error, 'h55);
    checkOutput("post_fill", fill_level, 1);
    applyStimulus(1'b0, '0, '0, 1'b1);
    checkOutput("post_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avalon.md
# sonic_v1_15_eth_10g_eth_10g_mac_rx_st_timing_adapter_status_input

Avalon-ST timing adapter that accepts 40-bit data and 7-bit error status from a source with no backpressure (no ready signal) and presents it to a sink that does apply ready. It sits between the MAC's free-running status producer and a ready-aware consumer. A small FIFO absorbs the stalls the sink introduces. Overflow is counted and flagged rather than silently lost.

## Interface
- DATA_W, 40, width of in_data/out_data
- ERR_W, 7, width of in_error/out_error
- DEPTH, 8, FIFO entries; power of two, 2..64
- AW, log2(DEPTH), pointer width (derived, not overridden)

- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  source word present this cycle. There is no in_ready; the source never stalls.
- in_data  in  DATA_W  source data.
- in_error  in  ERR_W  source error bits, carried alongside in_data.
- out_ready  in  1  sink accepts the word on out_* this cycle.
- out_valid  out  1  FIFO head is valid.
- out_data  out  DATA_W  head data.
- out_error  out  ERR_W  head error bits.
- fill_level  out  AW+1  number of occupied entries, 0..DEPTH.
- overflow  out  1  sticky; set on the first dropped word.
- drop_count  out  8  number of dropped words; saturates at 255.

## Operation
- Storage: DEPTH x (DATA_W+ERR_W) register array, payload ordered {data,error}.
- Pointers: wr_ptr and rd_ptr, AW bits each, wrapping modulo DEPTH. count is AW+1 bits.
- push = in_valid && (count < DEPTH || pop).
- pop = out_valid && out_ready.
- drop = in_valid && !push. This can occur only when count == DEPTH and out_ready == 0.
- On push: mem[wr_ptr] <= payload, and wr_ptr increments.
- On pop: rd_ptr increments.
- count update: count += push - pop. A simultaneous push and pop leaves count unchanged.
- Full with a pop in the same cycle: the incoming word is accepted and nothing is dropped.
- Empty with in_valid: the word is written. out_valid rises the next cycle; there is no same-cycle bypass.
- out_valid = (count != 0).
- out_data/out_error = mem[rd_ptr], read combinationally from the registers.
- out_data/out_error are don't-care when out_valid = 0, but still drive the array contents.
- On drop: overflow <= 1, and drop_count increments, saturating at 255.
- The overflow flag and drop_count clear only on reset.
- Order is preserved. Error bits always travel with their data word and are never modified.
- out_ready while out_valid = 0 has no effect.

## Timing
- Reset (asynchronous assert, synchronous release): all of the following are 0 immediately on reset assertion:
  - wr_ptr, rd_ptr, count
  - overflow, drop_count, fill_level, out_valid
  - the entire storage array, so out_data = 0 and out_error = 0
- Latency: a word pushed in cycle N is at the head (out_valid = 1) in cycle N+1 if the FIFO was empty.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- fill_level reflects count after the previous edge and is registered.
- Reset asserted mid-stream discards all buffered words. After release the block behaves as just reset, and in_valid is honoured from the first clock edge after release.
- Pointer wrap from DEPTH-1 to 0 is seamless and shows no bubble on out_valid.

## Test plan
- Pass-through: out_ready = 1, 20 consecutive in_valid words with data = 0x00_0000_0000 + i and error = i[6:0].
  - Required: each word appears one cycle later in order.
  - Required: fill_level never exceeds 1; overflow = 0.
- Fill and drain: out_ready = 0, push exactly 8 words (DEPTH = 8).
  - Required: fill_level = 8, overflow = 0.
  - Then raise out_ready: 8 words come out in order on 8 consecutive cycles, then out_valid = 0 and fill_level = 0.
- Overflow: out_ready = 0, push 11 words.
  - Required: words 0..7 are retained and words 8..10 are dropped.
  - Required: overflow = 1, drop_count = 3; drain yields words 0..7 only.
- Full with simultaneous pop: FIFO full, one cycle with in_valid = 1 and out_ready = 1.
  - Required: head popped, new word accepted, fill_level stays 8, drop_count unchanged.
- Wrap and saturation:
  - Random out_ready (50%) over 1000 continuous pushes with a scoreboard. Required: no reordering, and every word is either delivered or counted as dropped.
  - Force more than 255 drops. Required: drop_count holds at 255.
- Reset mid-operation: fill 5 words, then assert reset_n = 0 for 1 cycle asynchronously between edges.
  - Required: out_valid, fill_level, overflow, drop_count, out_data and out_error read 0 immediately.
  - Required: a word pushed after release appears at the head one cycle later.
